// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores against a req/ack data memory and stalls until done.
// Optional ack-wait abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ex_mem_out_RegSrc,
  input  logic              ex_mem_out_RegWrite,
  input  logic              ex_mem_out_MemRead,
  input  logic              ex_mem_out_MemWrite,
  input  logic [31:0]       ex_mem_out_ALUOut_EXEC,
  input  logic [31:0]       ex_mem_out_store_data,
  input  logic [4:0]        ex_mem_out_write_reg_dest,
  input  logic [15:0]       ex_mem_out_immediate,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_timeout,
  output logic [1:0]        mem_wb_in_RegSrc,
  output logic              mem_wb_in_RegWrite,
  output logic [31:0]       mem_wb_in_ALUOut_EXEC,
  output logic [31:0]       mem_wb_in_Mem_dataOut,
  output logic [4:0]        mem_wb_in_write_reg_dest,
  output logic [15:0]       mem_wb_in_immediate
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_rdata;
  logic        r_timed_out;
  logic        w_mem_op;
  logic        w_aligned;
  logic        w_issue;
  logic        w_timeout_hit;

  assign w_mem_op  = ex_mem_out_MemRead | ex_mem_out_MemWrite;
  assign w_aligned = (ex_mem_out_ALUOut_EXEC[1:0] == 2'b00);
  // rst_n gating keeps the request low while reset is held with a memory op upstream
  assign w_issue   = rst_n && (r_state == S_IDLE) && w_mem_op && w_aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state != S_WAIT) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout_hit = (r_state == S_WAIT) && !dmem_ack &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = (TIMEOUT_CYCLES > 0);
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rdata     <= 32'h0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timed_out <= w_timeout_hit;
      if ((w_issue || r_state == S_WAIT) && dmem_ack)
        r_rdata <= ex_mem_out_MemWrite ? 32'h0 : dmem_rdata;
      else if (w_timeout_hit)
        r_rdata <= 32'hDEAD_BEEF;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_next = dmem_ack ? S_DONE : S_WAIT;
      S_WAIT:  if (dmem_ack || w_timeout_hit) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req                 = 1'b0;
    dmem_we                  = 1'b0;
    dmem_addr                = {ex_mem_out_ALUOut_EXEC[ADDR_W-1:2], 2'b00};
    dmem_wdata               = ex_mem_out_store_data;
    mem_stall                = 1'b0;
    mem_misalign             = 1'b0;
    mem_timeout              = 1'b0;
    mem_wb_in_RegSrc         = ex_mem_out_RegSrc;
    mem_wb_in_RegWrite       = ex_mem_out_RegWrite;
    mem_wb_in_ALUOut_EXEC    = ex_mem_out_ALUOut_EXEC;
    mem_wb_in_Mem_dataOut    = 32'h0;
    mem_wb_in_write_reg_dest = ex_mem_out_write_reg_dest;
    mem_wb_in_immediate      = ex_mem_out_immediate;
    case (r_state)
      S_IDLE: begin
        if (rst_n && w_mem_op) begin
          mem_wb_in_RegWrite = 1'b0;
          if (!w_aligned) begin
            mem_misalign = 1'b1;
          end else begin
            dmem_req  = 1'b1;
            dmem_we   = ex_mem_out_MemWrite;
            mem_stall = 1'b1;
          end
        end
      end
      S_WAIT: begin
        dmem_req           = 1'b1;
        dmem_we            = ex_mem_out_MemWrite;
        mem_stall          = 1'b1;
        mem_wb_in_RegWrite = 1'b0;
      end
      S_DONE: begin
        // stores (including MemRead+MemWrite) never write back
        mem_wb_in_RegWrite    = ex_mem_out_RegWrite & ~ex_mem_out_MemWrite & ~r_timed_out;
        mem_wb_in_Mem_dataOut = r_rdata;
        mem_timeout           = r_timed_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a transaction-level memory model.
// Optional timeout checks run when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;
  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int MAXLAT = TMO - 1;
`else
  localparam int MAXLAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ex_RegSrc = '0;
  logic        ex_RegWrite = 1'b0, ex_MemRead = 1'b0, ex_MemWrite = 1'b0;
  logic [31:0] ex_ALUOut = '0, ex_store = '0;
  logic [4:0]  ex_dest = '0;
  logic [15:0] ex_imm = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        mem_stall, mem_misalign, mem_timeout;
  logic [1:0]  wb_RegSrc;
  logic        wb_RegWrite;
  logic [31:0] wb_ALUOut, wb_data;
  logic [4:0]  wb_dest;
  logic [15:0] wb_imm;

  int n_checks = 0;
  int n_fail = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_out_RegSrc(ex_RegSrc), .ex_mem_out_RegWrite(ex_RegWrite),
    .ex_mem_out_MemRead(ex_MemRead), .ex_mem_out_MemWrite(ex_MemWrite),
    .ex_mem_out_ALUOut_EXEC(ex_ALUOut), .ex_mem_out_store_data(ex_store),
    .ex_mem_out_write_reg_dest(ex_dest), .ex_mem_out_immediate(ex_imm),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_timeout(mem_timeout),
    .mem_wb_in_RegSrc(wb_RegSrc), .mem_wb_in_RegWrite(wb_RegWrite),
    .mem_wb_in_ALUOut_EXEC(wb_ALUOut), .mem_wb_in_Mem_dataOut(wb_data),
    .mem_wb_in_write_reg_dest(wb_dest), .mem_wb_in_immediate(wb_imm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic req, input logic stall,
                         input logic mis, input logic tmo);
    chk({tag, ".req"}, dmem_req, req);
    chk({tag, ".stall"}, mem_stall, stall);
    chk({tag, ".misalign"}, mem_misalign, mis);
    chk({tag, ".timeout"}, mem_timeout, tmo);
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic [31:0] data);
    chk({tag, ".RegSrc"}, wb_RegSrc, ex_RegSrc);
    chk({tag, ".RegWrite"}, wb_RegWrite, rw);
    chk({tag, ".ALUOut"}, wb_ALUOut, ex_ALUOut);
    chk({tag, ".dataOut"}, wb_data, data);
    chk({tag, ".dest"}, wb_dest, ex_dest);
    chk({tag, ".imm"}, wb_imm, ex_imm);
  endtask

  // Called just after a rising edge; returns just after the rising edge that ends the instruction.
  // lat = cycles from the request cycle to ack (0 = same cycle, -1 = never).
  task automatic run_txn(input string tag, input logic rd, input logic wr, input logic rw,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdat, input logic [4:0] dest, input int lat);
    logic mem_op, aligned, timed_out;
    logic [31:0] exp_addr;
    int stalls;
    ex_RegSrc = 2'($urandom); ex_RegWrite = rw; ex_MemRead = rd; ex_MemWrite = wr;
    ex_ALUOut = addr; ex_store = sdata; ex_dest = dest; ex_imm = 16'($urandom);
    mem_op = rd | wr;
    aligned = (addr[1:0] == 2'b00);
    exp_addr = {addr[31:2], 2'b00};
    timed_out = 1'b0;
    stalls = 0;
    n_txn++;
    $display("txn %0d %s rd=%0b wr=%0b addr=%h lat=%0d", n_txn, tag, rd, wr, addr, lat);
    if (!mem_op || !aligned) begin
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      @(negedge clk);
      chk_ctl(tag, 1'b0, 1'b0, mem_op, 1'b0);
      chk_wb(tag, mem_op ? 1'b0 : rw, 32'h0);
      @(posedge clk); #1;
      return;
    end
    for (int c = 0; ; c++) begin
      dmem_ack = (c == lat);
      dmem_rdata = (c == lat) ? rdat : $urandom;
      @(negedge clk);
      chk_ctl(tag, 1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, ".we"}, dmem_we, wr);
      chk({tag, ".addr"}, dmem_addr, exp_addr);
      if (wr) chk({tag, ".wdata"}, dmem_wdata, sdata);
      chk({tag, ".bubble"}, wb_RegWrite, 1'b0);
      stalls++;
      @(posedge clk); #1;
      if (c == lat) break;
`ifdef MEM_TIMEOUT_EN
      if (lat < 0 && c == TMO) begin
        timed_out = 1'b1;
        break;
      end
`endif
      if (c > 200) begin
        chk({tag, ".ack_wait_bound"}, 32'(c), 32'(lat));
        break;
      end
    end
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    chk_ctl({tag, ".done"}, 1'b0, 1'b0, 1'b0, timed_out);
    chk_wb({tag, ".done"}, timed_out ? 1'b0 : (rw & ~wr),
           timed_out ? 32'hDEAD_BEEF : (wr ? 32'h0 : rdat));
    if (lat >= 0) chk({tag, ".stall_cycles"}, 32'(stalls), 32'(lat + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    // reset state with a load presented upstream: nothing may be requested
    ex_MemRead = 1'b1; ex_ALUOut = 32'h40; dmem_ack = 1'b1;
    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_MemRead = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset asserted mid-WAIT drops the request immediately
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_ALUOut = 32'h80; dmem_ack = 1'b0;
    @(negedge clk); chk_ctl("rst_req", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk_ctl("rst_wait", 1'b1, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_MemRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk_ctl("stale_ack", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_wb("stale_ack", 1'b1, 32'h0);
    @(posedge clk); #1;

    run_txn("alu", 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h0, 5'd5, 0);
    run_txn("load40", 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'hCAFE_F00D, 5'd7, 3);
    run_txn("store44", 1'b0, 1'b1, 1'b0, 32'h44, 32'h1234_5678, 32'h0, 5'd9, 0);
    run_txn("misalign42", 1'b1, 1'b0, 1'b1, 32'h42, 32'h0, 32'h0, 5'd3, 0);
    run_txn("rdwr", 1'b1, 1'b1, 1'b1, 32'h100, 32'hA5A5_0F0F, 32'h7777_1111, 5'd11, 2);
`ifdef MEM_TIMEOUT_EN
    run_txn("timeout", 1'b1, 1'b0, 1'b1, 32'h48, 32'h0, 32'h0, 5'd4, -1);
    run_txn("after_tmo", 1'b1, 1'b0, 1'b1, 32'h4C, 32'h0, 32'h0BAD_F00D, 5'd6, 1);
`endif

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      if (kind != 4) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[0] = 1'b1;
      case (kind)
        0: run_txn("r_alu", 1'b0, 1'b0, 1'($urandom), a, $urandom, $urandom, 5'($urandom), 0);
        1: run_txn("r_load", 1'b1, 1'b0, 1'($urandom), a, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, MAXLAT));
        2: run_txn("r_store", 1'b0, 1'b1, 1'($urandom), a, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, MAXLAT));
        3: run_txn("r_rdwr", 1'b1, 1'b1, 1'($urandom), a, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, MAXLAT));
        default: run_txn("r_misalign", 1'($urandom), 1'b1, 1'($urandom), a, $urandom,
                         $urandom, 5'($urandom), 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes EX results and control signals, runs loads and stores against a variable-latency data memory over a req/ack handshake, and stalls the pipeline until the access completes.
- Drives the mem_wb_in_* inputs of the MEM/WB register, inserting bubbles while stalled.

Parameters:
- ADDR_W, 32, data-memory address width; the low ADDR_W bits of ALUOut are used.
- TIMEOUT_CYCLES, 64, ack-wait limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_mem_out_RegSrc  in  2  write-back source select; passed through.
- ex_mem_out_RegWrite  in  1  register-write enable.
- ex_mem_out_MemRead  in  1  load request.
- ex_mem_out_MemWrite  in  1  store request.
- ex_mem_out_ALUOut_EXEC  in  32  ALU result and memory address.
- ex_mem_out_store_data  in  32  store data.
- ex_mem_out_write_reg_dest  in  5  destination register.
- ex_mem_out_immediate  in  16  immediate; passed through.
- dmem_req  out  1  memory request; held until ack.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_W  word address (byte address, low 2 bits always 0).
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data; valid in the ack cycle.
- dmem_ack  in  1  single-cycle completion strobe.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- mem_misalign  out  1  one-cycle pulse: misaligned access dropped.
- mem_timeout  out  1  one-cycle pulse: access aborted (feature only; tied 0 otherwise).
- mem_wb_in_RegSrc  out  2  to MEM/WB register.
- mem_wb_in_RegWrite  out  1  to MEM/WB register.
- mem_wb_in_ALUOut_EXEC  out  32  to MEM/WB register.
- mem_wb_in_Mem_dataOut  out  32  to MEM/WB register.
- mem_wb_in_write_reg_dest  out  5  to MEM/WB register.
- mem_wb_in_immediate  out  16  to MEM/WB register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; dmem_req, dmem_we, mem_stall, mem_misalign, mem_timeout = 0; read-data latch = 0; timeout counter = 0.
- Reset mid-access drops dmem_req immediately; the outstanding access is abandoned.
- States: IDLE, WAIT, DONE.
- Memory op = MemRead | MemWrite. If both are set, treat as a store: we=1, RegWrite forced 0.
- IDLE, no memory op:
  - All mem_wb_in_* are combinational pass-through of the EX/MEM fields; mem_wb_in_Mem_dataOut = 0.
  - mem_stall = 0. Zero added latency.
- IDLE, memory op, ALUOut[1:0] != 0 (misaligned):
  - No request issued; mem_misalign = 1 for that cycle.
  - Pass-through with mem_wb_in_RegWrite forced 0; no stall.
- IDLE, memory op, aligned:
  - dmem_req = 1 and mem_stall = 1 combinationally in the same cycle.
  - dmem_addr = {ALUOut[ADDR_W-1:2], 2'b00}; dmem_wdata = store_data; dmem_we = MemWrite.
  - If dmem_ack is already high that cycle, go straight to DONE; otherwise go to WAIT.
  - In every stall cycle, mem_wb_in_RegWrite is forced 0 (bubble).
- WAIT: dmem_req, address, data and we held stable; mem_stall = 1. On dmem_ack, latch dmem_rdata (loads only) and go to DONE.
- DONE (exactly 1 cycle):
  - mem_stall = 0; dmem_req = 0.
  - mem_wb_in_* carry the EX/MEM fields; Mem_dataOut = latched read data (0 for stores).
  - Next state IDLE, so the following instruction is evaluated the cycle after.
- Minimum load/store latency: 2 cycles (request cycle + DONE).
- Upstream holds the EX/MEM fields stable while mem_stall = 1; the block does not re-latch them.
- dmem_ack is ignored whenever dmem_req = 0; a stale ack after reset has no effect.
- The memory must not ack earlier than the cycle dmem_req rises.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without ack: drop dmem_req, pulse mem_timeout for 1 cycle, go to DONE with mem_wb_in_RegWrite forced 0 and Mem_dataOut = 32'hDEAD_BEEF.
- Not defined: no counter; WAIT waits indefinitely; mem_timeout tied 0.

Test Plan:
- Reset behaviour: rst_n low mid-WAIT → dmem_req and mem_stall go to 0 immediately; after release, state IDLE. Then ack=1 while req=0 → no output change.
- Non-memory ALU op, ALUOut=32'h0000_0010, RegWrite=1, dest=5 → same cycle mem_wb_in_ALUOut_EXEC=32'h10, RegWrite=1, dest=5, mem_stall=0.
- Load, addr 32'h40, memory acks after 3 cycles with rdata=32'hCAFE_F00D → mem_stall high 4 cycles with RegWrite=0 throughout; DONE cycle Mem_dataOut=32'hCAFE_F00D, RegWrite=1, dest unchanged.
- Store, addr 32'h44, data 32'h1234_5678, same-cycle ack → dmem_we=1, dmem_wdata=32'h1234_5678; 1 stall cycle then DONE with RegWrite=0.
- Load at addr 32'h42 → no dmem_req, mem_misalign pulse for 1 cycle, RegWrite=0, mem_stall=0.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, ack never arrives → after 4 WAIT cycles mem_timeout pulses, dmem_req drops, DONE presents Mem_dataOut=32'hDEAD_BEEF with RegWrite=0.
